// File: rtl/nrzi_pkg.sv
// Shared types and constants for the NRZI encoder and decoder benches.
package nrzi_pkg;

  localparam int unsigned CNT_W             = 3;
  localparam int unsigned STUFF_LEN_DEFAULT = 6;

  // SYNC pattern, LSB sent first: 0,0,0,0,0,0,0,1
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_DATA  = 2'd2,
    ST_STUFF = 2'd3
  } nrzi_state_e;

endpackage

// File: rtl/nrzi_bit_stuffer.sv
// Bit stuffer: packet FSM, ones counter and ready generation.
// Emits one registered line bit per cycle (before NRZI coding).
// Build option NRZI_ENCODE_SYNC_EN prepends the 8-bit SYNC pattern to each packet.
module nrzi_bit_stuffer
  import nrzi_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  input  logic i_valid,
  input  logic i_last,
  output logic o_ready_c,
  output logic o_bit,
  output logic o_bit_valid,
  output logic o_underrun
);

  localparam logic [CNT_W-1:0] STUFF_CNT = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(7);

  nrzi_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;   // ones count; SYNC bit index while in SYNC
  logic             last_q, last_d;     // i_last seen on the beat that triggered STUFF
  logic             bit_q, bit_d;
  logic             bit_valid_q, bit_valid_d;
  logic             underrun_q, underrun_d;
  logic             xfer;
  logic [CNT_W-1:0] count_inc;

  // Accept only in DATA, or in IDLE once the previous packet's last bit has left,
  // which guarantees a one-cycle o_valid gap between back-to-back packets.
  always_comb begin
`ifdef NRZI_ENCODE_SYNC_EN
    o_ready_c = (state_q == ST_DATA);
`else
    o_ready_c = (state_q == ST_DATA) || ((state_q == ST_IDLE) && !bit_valid_q);
`endif
  end

  assign xfer      = i_valid & o_ready_c;
  assign count_inc = count_q + CNT_W'(1);

  // State and stage registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      last_q      <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  // Next-state and emitted-bit logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    last_d      = last_q;
    bit_d       = 1'b0;
    bit_valid_d = 1'b0;
    underrun_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
`ifdef NRZI_ENCODE_SYNC_EN
        if (i_valid && !bit_valid_q) begin
          state_d = ST_SYNC;
        end
`else
        if (xfer) begin
          bit_d       = i_data;
          bit_valid_d = 1'b1;
          if (i_data && (count_inc == STUFF_CNT)) begin
            count_d = count_inc;
            last_d  = i_last;
            state_d = ST_STUFF;
          end else begin
            count_d = (i_data && !i_last) ? count_inc : '0;
            state_d = i_last ? ST_IDLE : ST_DATA;
          end
        end
`endif
      end

      ST_SYNC: begin
        bit_d       = SYNC_PATTERN[count_q];
        bit_valid_d = 1'b1;
        count_d     = count_inc;
        if (count_q == SYNC_END) begin
          count_d = CNT_W'(1);
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (!i_valid) begin
          underrun_d = 1'b1;
          count_d    = '0;
          state_d    = ST_IDLE;
        end else begin
          bit_d       = i_data;
          bit_valid_d = 1'b1;
          if (i_data && (count_inc == STUFF_CNT)) begin
            count_d = count_inc;
            last_d  = i_last;
            state_d = ST_STUFF;
          end else begin
            count_d = (i_data && !i_last) ? count_inc : '0;
            state_d = i_last ? ST_IDLE : ST_DATA;
          end
        end
      end

      ST_STUFF: begin
        bit_d       = 1'b0;
        bit_valid_d = 1'b1;
        count_d     = '0;
        state_d     = last_q ? ST_IDLE : ST_DATA;
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_underrun  = underrun_q;

endmodule

// File: rtl/nrzi_encode.sv
// NRZI transmit path: bit stuffer followed by the NRZI line-level register.
// 0 toggles the line, 1 holds it; the line rests at IDLE_LEVEL between packets.
// Build option NRZI_ENCODE_SYNC_EN (handled in nrzi_bit_stuffer) adds a SYNC preamble.
module nrzi_encode
  import nrzi_pkg::*;
#(
  parameter int unsigned STUFF_LEN  = STUFF_LEN_DEFAULT,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  input  logic i_valid,
  input  logic i_last,
  output logic o_ready,
  output logic o_nrzi,
  output logic o_valid,
  output logic o_underrun
);

  logic stuff_bit;
  logic stuff_bit_valid;
  logic stuff_underrun;

  nrzi_bit_stuffer #(
    .STUFF_LEN (STUFF_LEN)
  ) u_stuffer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready_c   (o_ready),
    .o_bit       (stuff_bit),
    .o_bit_valid (stuff_bit_valid),
    .o_underrun  (stuff_underrun)
  );

  // Line level: toggle on 0, hold on 1, re-arm to IDLE_LEVEL whenever no bit is sent
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_nrzi     <= IDLE_LEVEL;
      o_valid    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_underrun <= stuff_underrun;
      o_valid    <= stuff_bit_valid;
      if (stuff_bit_valid) begin
        o_nrzi <= stuff_bit ? o_nrzi : ~o_nrzi;
      end else begin
        o_nrzi <= IDLE_LEVEL;
      end
    end
  end

endmodule

// File: tb/tb_nrzi_encode.sv
// Directed bench for nrzi_encode: hand-written reset sequences plus vector tables.
module tb_nrzi_encode;

  logic i_clk;
  logic i_rst;
  logic i_data;
  logic i_valid;
  logic i_last;
  logic o_ready;
  logic o_nrzi;
  logic o_valid;
  logic o_underrun;

  int checks;
  int failures;

  typedef struct {
    logic v;
    logic d;
    logic l;
    logic rdy;   // o_ready before the edge
    logic ov;    // o_valid after the edge
    logic on;    // o_nrzi after the edge
    logic ou;    // o_underrun after the edge
  } vec_t;

  vec_t tbl[$];

`ifdef NRZI_ENCODE_SYNC_EN
  localparam logic RST_READY = 1'b0;
`else
  localparam logic RST_READY = 1'b1;
`endif

  nrzi_encode dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_nrzi     (o_nrzi),
    .o_valid    (o_valid),
    .o_underrun (o_underrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%b expected=%b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic d, input logic l, input logic rdy,
                     input logic ov, input logic on, input logic ou);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.rdy = rdy; r.ov = ov; r.on = on; r.ou = ou;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_line(input string name, input int idx,
                            input logic ov, input logic on, input logic ou);
    chk({name, "_valid"}, idx, o_valid, ov);
    chk({name, "_nrzi"}, idx, o_nrzi, on);
    chk({name, "_underrun"}, idx, o_underrun, ou);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_rst    = 1'b1;
    i_data   = 1'b0;
    i_valid  = 1'b0;
    i_last   = 1'b0;
    step();
    step();
    check_line("por", 0, 1'b0, 1'b1, 1'b0);
    chk("por_ready", 0, o_ready, RST_READY);
    i_rst = 1'b0;

    // Reset held 3 cycles in the middle of a packet
    i_valid = 1'b1; i_data = 1'b1;
    step();
    step();
    i_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_line("rst_mid", k, 1'b0, 1'b1, 1'b0);
      chk("rst_mid_ready", k, o_ready, RST_READY);
    end
    i_rst = 1'b0; i_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_line("rst_after", k, 1'b0, 1'b1, 1'b0);
    end

`ifndef NRZI_ENCODE_SYNC_EN
    // Reset while a stuff bit is pending: no stuff bit may appear afterwards
    i_valid = 1'b1; i_data = 1'b1;
    for (int k = 0; k < 6; k++) step();
    i_rst = 1'b1;
    step();
    check_line("rst_stuff", 0, 1'b0, 1'b1, 1'b0);
    i_rst = 1'b0; i_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_line("rst_stuff_after", k, 1'b0, 1'b1, 1'b0);
    end

    // Payload 1,0,0,1 -> line 1,0,1,1
    add(1,1,0, 1, 0,1,0);
    add(1,0,0, 1, 1,1,0);
    add(1,0,0, 1, 1,0,0);
    add(1,1,1, 1, 1,1,0);
    add(0,1,1, 0, 1,1,0);
    add(0,0,0, 1, 0,1,0);
    // Eight ones -> 1 x6, stuffed 0, then two held lows; ready drops once
    add(1,1,0, 1, 0,1,0);
    add(1,1,0, 1, 1,1,0);
    add(1,1,0, 1, 1,1,0);
    add(1,1,0, 1, 1,1,0);
    add(1,1,0, 1, 1,1,0);
    add(1,1,0, 1, 1,1,0);
    add(1,1,0, 0, 1,1,0);
    add(1,1,0, 1, 1,0,0);
    add(1,1,1, 1, 1,0,0);
    add(0,0,0, 0, 1,0,0);
    add(0,0,0, 1, 0,1,0);
    // Packet ending on the sixth 1: stuff still sent, o_valid high 7 cycles
    add(1,1,0, 1, 0,1,0);
    add(1,1,0, 1, 1,1,0);
    add(1,1,0, 1, 1,1,0);
    add(1,1,0, 1, 1,1,0);
    add(1,1,0, 1, 1,1,0);
    add(1,1,1, 1, 1,1,0);
    add(0,0,0, 0, 1,1,0);
    add(0,1,1, 0, 1,0,0);
    add(0,0,0, 1, 0,1,0);
    // Underrun after 3 bits, then a new packet 0,0 encoded from level 1
    add(1,1,0, 1, 0,1,0);
    add(1,0,0, 1, 1,1,0);
    add(1,1,0, 1, 1,0,0);
    add(0,1,1, 1, 1,0,0);
    add(0,0,0, 1, 0,1,1);
    add(1,0,0, 1, 0,1,0);
    add(1,0,1, 1, 1,0,0);
    add(0,0,0, 0, 1,1,0);
    add(0,0,0, 1, 0,1,0);
`else
    // SYNC build: payload 1 x5 then 0; SYNC's final 1 counts toward stuffing
    add(1,1,0, 0, 0,1,0);
    add(1,1,0, 0, 0,1,0);
    add(1,1,0, 0, 1,0,0);
    add(1,1,0, 0, 1,1,0);
    add(1,1,0, 0, 1,0,0);
    add(1,1,0, 0, 1,1,0);
    add(1,1,0, 0, 1,0,0);
    add(1,1,0, 0, 1,1,0);
    add(1,1,0, 0, 1,0,0);
    add(1,1,0, 1, 1,0,0);
    add(1,1,0, 1, 1,0,0);
    add(1,1,0, 1, 1,0,0);
    add(1,1,0, 1, 1,0,0);
    add(1,1,0, 1, 1,0,0);
    add(1,0,1, 0, 1,0,0);
    add(1,0,1, 1, 1,1,0);
    add(0,0,0, 0, 1,0,0);
    add(0,0,0, 0, 0,1,0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      i_valid = tbl[i].v;
      i_data  = tbl[i].d;
      i_last  = tbl[i].l;
      #1;
      chk("ready", i, o_ready, tbl[i].rdy);
      step();
      check_line("vec", i, tbl[i].ov, tbl[i].on, tbl[i].ou);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
